// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared keypad scanner types, sizes and helpers
// Matrix geometry, key-code width and scan FSM state encodings.
package keypad_pkg;

  localparam int KEY_ROWS   = 4;
  localparam int KEY_COLS   = 4;
  localparam int KEY_CODE_W = 4;

  typedef logic [1:0] kp_state_t;

  localparam kp_state_t ST_SCAN     = 2'd0;
  localparam kp_state_t ST_DEBOUNCE = 2'd1;
  localparam kp_state_t ST_HELD     = 2'd2;
  localparam kp_state_t ST_RELEASE  = 2'd3;

  // Columns are active-low; index of the lowest-numbered pulled-down column.
  function automatic logic [1:0] lowest_low_col(input logic [KEY_COLS-1:0] cols);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = KEY_COLS - 1; i >= 0; i--) begin
      if (!cols[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - column synchronizer plus saturating stable-sample counter
// The scan FSM decides when to clear and when to count; the counter stops at DEBOUNCE_CYCLES-1.
module key_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic                IN_clk,
  input  logic                IN_reset,
  input  logic [KEY_COLS-1:0] col_async,
  input  logic                cnt_clear,
  input  logic                cnt_inc,
  output logic [KEY_COLS-1:0] col_sync,
  output logic                cnt_done
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [KEY_COLS-1:0] sync_q1;
  logic [CNT_W-1:0]    cnt;

  assign cnt_done = (cnt == CNT_LAST);

  // Idle columns are pulled up, so the synchronizer resets to all-ones.
  always_ff @(posedge IN_clk or negedge IN_reset) begin
    if (!IN_reset) begin
      sync_q1  <= '1;
      col_sync <= '1;
      cnt      <= '0;
    end else begin
      sync_q1  <= col_async;
      col_sync <= sync_q1;
      if (cnt_clear) begin
        cnt <= '0;
      end else if (cnt_inc && !cnt_done) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// rtl/keypad_scan.sv - 4x4 active-low keypad row scanner with debounced key strobe
// Define KEYPAD_SCAN_REPEAT_EN to add auto-repeat strobes while a key stays held.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_CYCLES     = 16,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int REPEAT_DELAY    = 500000,
  parameter int REPEAT_PERIOD   = 100000
) (
  input  logic                  IN_clk,
  input  logic                  IN_reset,
  input  logic [KEY_COLS-1:0]   IN_col,
  output logic [KEY_ROWS-1:0]   OUT_row,
  output logic [KEY_CODE_W-1:0] OUT_value,
  output logic                  OUT_key,
  output logic                  OUT_held
);

  localparam logic [15:0]         SCAN_LAST = 16'(SCAN_CYCLES - 1);
  localparam logic [KEY_ROWS-1:0] ROW0      = KEY_ROWS'(1);

  kp_state_t           state;
  logic [1:0]          row_idx;
  logic [1:0]          col_idx;
  logic [KEY_COLS-1:0] col_latched;
  logic [15:0]         scan_cnt;
  logic [KEY_COLS-1:0] col_sync;
  logic                cnt_clear;
  logic                cnt_inc;
  logic                cnt_done;
  logic                scan_last;
  logic                col_low;
  logic                pattern_stable;
  logic                strobe_now;
  logic                rpt_fire;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .IN_clk   (IN_clk),
    .IN_reset (IN_reset),
    .col_async(IN_col),
    .cnt_clear(cnt_clear),
    .cnt_inc  (cnt_inc),
    .col_sync (col_sync),
    .cnt_done (cnt_done)
  );

  assign scan_last      = (scan_cnt == SCAN_LAST);
  assign col_low        = !col_sync[col_idx];
  assign pattern_stable = col_low && (col_sync == col_latched);
  assign strobe_now     = (state == ST_DEBOUNCE) && pattern_stable && cnt_done;
  assign OUT_row        = ~(ROW0 << row_idx);

  always_comb begin
    cnt_clear = 1'b0;
    cnt_inc   = 1'b0;
    case (state)
      ST_DEBOUNCE: cnt_inc   = pattern_stable;
      ST_RELEASE:  cnt_inc   = !col_low;
      default:     cnt_clear = 1'b1;
    endcase
  end

  always_ff @(posedge IN_clk or negedge IN_reset) begin
    if (!IN_reset) begin
      state       <= ST_SCAN;
      row_idx     <= 2'd0;
      col_idx     <= 2'd0;
      col_latched <= '1;
      scan_cnt    <= '0;
      OUT_value   <= '0;
      OUT_key     <= 1'b0;
      OUT_held    <= 1'b0;
    end else begin
      OUT_key <= 1'b0;
      case (state)
        ST_SCAN: begin
          if (!scan_last) begin
            scan_cnt <= scan_cnt + 16'd1;
          end else begin
            scan_cnt <= '0;
            if (&col_sync) begin
              row_idx <= row_idx + 2'd1;
            end else begin
              col_idx     <= lowest_low_col(col_sync);
              col_latched <= col_sync;
              state       <= ST_DEBOUNCE;
            end
          end
        end
        ST_DEBOUNCE: begin
          if (!pattern_stable) begin
            row_idx <= row_idx + 2'd1;
            state   <= ST_SCAN;
          end else if (cnt_done) begin
            OUT_value <= {row_idx, col_idx};
            OUT_key   <= 1'b1;
            OUT_held  <= 1'b1;
            state     <= ST_HELD;
          end
        end
        // Only the latched column matters here; other keys are ignored.
        ST_HELD: begin
          if (!col_low) begin
            state <= ST_RELEASE;
          end else if (rpt_fire) begin
            OUT_key <= 1'b1;
          end
        end
        ST_RELEASE: begin
          if (col_low) begin
            state <= ST_HELD;
          end else if (cnt_done) begin
            OUT_held <= 1'b0;
            row_idx  <= row_idx + 2'd1;
            state    <= ST_SCAN;
          end
        end
        default: state <= ST_SCAN;
      endcase
    end
  end

`ifdef KEYPAD_SCAN_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] RPT_FIRST = RPT_W'(REPEAT_DELAY);
  localparam logic [RPT_W-1:0] RPT_NEXT  = RPT_W'(REPEAT_PERIOD);

  logic [RPT_W-1:0] rpt_cnt;
  logic             rpt_first;

  assign rpt_fire = (state == ST_HELD) && col_low &&
                    (rpt_cnt == (rpt_first ? RPT_FIRST : RPT_NEXT));

  // Timer counts clocks since the last strobe, advancing only while truly held.
  always_ff @(posedge IN_clk or negedge IN_reset) begin
    if (!IN_reset) begin
      rpt_cnt   <= '0;
      rpt_first <= 1'b1;
    end else if (strobe_now) begin
      rpt_cnt   <= RPT_W'(1);
      rpt_first <= 1'b1;
    end else if (rpt_fire) begin
      rpt_cnt   <= RPT_W'(1);
      rpt_first <= 1'b0;
    end else if ((state == ST_HELD) && col_low && (rpt_cnt != '1)) begin
      rpt_cnt <= rpt_cnt + 1'b1;
    end
  end
`else
  logic unused_repeat_cfg;

  // Repeat timing has no effect in this build.
  assign unused_repeat_cfg = ^{32'(REPEAT_DELAY), 32'(REPEAT_PERIOD), strobe_now};
  assign rpt_fire          = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_scan.sv
// tb/tb_keypad_scan.sv - directed bench for keypad_scan with a behavioural key matrix
// Expectations follow the KEYPAD_SCAN_REPEAT_EN setting of the build.
module tb_keypad_scan;

  localparam int SCAN_CYCLES     = 4;
  localparam int DEBOUNCE_CYCLES = 8;
  localparam int REPEAT_DELAY    = 40;
  localparam int REPEAT_PERIOD   = 10;
  localparam int MAX_LATENCY     = 4 * SCAN_CYCLES + DEBOUNCE_CYCLES + 3;

  logic        IN_clk = 1'b0;
  logic        IN_reset = 1'b1;
  logic [3:0]  IN_col;
  logic [3:0]  OUT_row;
  logic [3:0]  OUT_value;
  logic        OUT_key;
  logic        OUT_held;
  logic [15:0] keys = '0;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int strobe_cnt = 0;
  int dbl_cnt = 0;
  logic prev_key = 1'b0;
  int strobe_cyc[$];
  int strobe_val[$];

  keypad_scan #(
    .SCAN_CYCLES    (SCAN_CYCLES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD)
  ) dut (
    .IN_clk   (IN_clk),
    .IN_reset (IN_reset),
    .IN_col   (IN_col),
    .OUT_row  (OUT_row),
    .OUT_value(OUT_value),
    .OUT_key  (OUT_key),
    .OUT_held (OUT_held)
  );

  always #5 IN_clk = ~IN_clk;

  // A pressed key shorts its column low while its row is driven low.
  always_comb begin
    IN_col = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!OUT_row[r] && keys[4*r+c]) IN_col[c] = 1'b0;
  end

  always @(posedge IN_clk) cyc <= cyc + 1;

  always @(negedge IN_clk) begin
    if (OUT_key === 1'b1) begin
      strobe_cnt <= strobe_cnt + 1;
      strobe_cyc.push_back(cyc);
      strobe_val.push_back(int'(OUT_value));
      if (prev_key === 1'b1) dbl_cnt <= dbl_cnt + 1;
    end
    prev_key <= OUT_key;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge IN_clk);
    #1;
  endtask

  task automatic wait_strobe(input int base, input int limit, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      tick(1);
      if (strobe_cnt > base) seen = 1'b1;
    end
  endtask

  task automatic test_reset;
    keys = '0;
    #3 IN_reset = 1'b0;
    #1;
    total++; if (OUT_row !== 4'b1110) begin bad++; $display("FAIL reset_row_async: got %b want 1110", OUT_row); end
    total++; if (OUT_key !== 1'b0) begin bad++; $display("FAIL reset_key_async: got %b want 0", OUT_key); end
    total++; if (OUT_held !== 1'b0) begin bad++; $display("FAIL reset_held_async: got %b want 0", OUT_held); end
    total++; if (OUT_value !== 4'd0) begin bad++; $display("FAIL reset_value_async: got %0d want 0", OUT_value); end
    tick(3);
    total++; if (OUT_row !== 4'b1110) begin bad++; $display("FAIL reset_row_hold: got %b want 1110", OUT_row); end
  endtask

  task automatic test_idle_rotation;
    int base;
    logic [3:0] exp_row;
    int row_bad;
    base = strobe_cnt;
    row_bad = 0;
    IN_reset = 1'b1;
    for (int k = 1; k <= 64; k++) begin
      tick(1);
      exp_row = ~(4'b0001 << ((k / 4) % 4));
      total++;
      if (OUT_row !== exp_row) begin
        bad++;
        if (row_bad < 4) $display("FAIL idle_row k=%0d: got %b want %b", k, OUT_row, exp_row);
        row_bad++;
      end
    end
    total++; if (strobe_cnt != base) begin bad++; $display("FAIL idle_no_key: got %0d strobes want 0", strobe_cnt - base); end
  endtask

  task automatic test_single_key;
    int base, press_cyc;
    bit seen;
    base = strobe_cnt;
    keys[9] = 1'b1;
    press_cyc = cyc;
    wait_strobe(base, 60, seen);
    total++; if (!seen) begin bad++; $display("FAIL single_strobe: got none want 1 within 60 cycles"); end
    if (seen) begin
      total++; if (strobe_cyc[base] - press_cyc > MAX_LATENCY) begin bad++; $display("FAIL single_latency: got %0d want <= %0d", strobe_cyc[base] - press_cyc, MAX_LATENCY); end
      total++; if (strobe_val[base] != 9) begin bad++; $display("FAIL single_value: got %0d want 9", strobe_val[base]); end
    end
    tick(100 - (cyc - press_cyc));
    total++; if (strobe_cnt - base != 1) begin bad++; $display("FAIL single_count: got %0d want 1", strobe_cnt - base); end
    total++; if (OUT_held !== 1'b1) begin bad++; $display("FAIL single_held: got %b want 1", OUT_held); end
    total++; if (OUT_value !== 4'd9) begin bad++; $display("FAIL single_value_stable: got %0d want 9", OUT_value); end
    keys[9] = 1'b0;
    tick(8);
    total++; if (OUT_held !== 1'b1) begin bad++; $display("FAIL single_held_release8: got %b want 1", OUT_held); end
    tick(6);
    total++; if (OUT_held !== 1'b0) begin bad++; $display("FAIL single_held_cleared: got %b want 0", OUT_held); end
    tick(10);
  endtask

  task automatic test_chatter;
    int base;
    bit seen;
    base = strobe_cnt;
    for (int i = 0; i < 50; i++) begin
      keys[3] = ((i / 3) % 2) == 0;
      tick(1);
    end
    total++; if (strobe_cnt != base) begin bad++; $display("FAIL chatter_no_strobe: got %0d want 0", strobe_cnt - base); end
    keys[3] = 1'b1;
    wait_strobe(base, 40, seen);
    total++; if (!seen) begin bad++; $display("FAIL chatter_strobe: got none want 1 within 40 cycles"); end
    total++; if (OUT_value !== 4'd3) begin bad++; $display("FAIL chatter_value: got %0d want 3", OUT_value); end
    tick(20);
    total++; if (strobe_cnt - base != 1) begin bad++; $display("FAIL chatter_count: got %0d want 1", strobe_cnt - base); end
    keys[3] = 1'b0;
    tick(25);
  endtask

  task automatic test_multi_col;
    int base;
    bit seen;
    base = strobe_cnt;
    keys[4] = 1'b1;
    keys[6] = 1'b1;
    wait_strobe(base, 40, seen);
    total++; if (!seen) begin bad++; $display("FAIL multi_strobe: got none want 1 within 40 cycles"); end
    total++; if (OUT_value !== 4'd4) begin bad++; $display("FAIL multi_value: got %0d want 4", OUT_value); end
    keys[12] = 1'b1;
    tick(20);
    total++; if (strobe_cnt - base != 1) begin bad++; $display("FAIL multi_other_row: got %0d strobes want 1", strobe_cnt - base); end
    total++; if (OUT_held !== 1'b1) begin bad++; $display("FAIL multi_held: got %b want 1", OUT_held); end
    keys[12] = 1'b0;
    tick(2);
    keys[4] = 1'b0;
    keys[6] = 1'b0;
    tick(25);
    total++; if (OUT_held !== 1'b0) begin bad++; $display("FAIL multi_release: got %b want 0", OUT_held); end
    total++; if (strobe_cnt - base != 1) begin bad++; $display("FAIL multi_total: got %0d want 1", strobe_cnt - base); end
  endtask

  task automatic test_reset_mid_press;
    int base, guard;
    bit seen;
    base = strobe_cnt;
    guard = 0;
    while (OUT_row === 4'b0111 && guard < 40) begin tick(1); guard++; end
    while (OUT_row !== 4'b0111 && guard < 40) begin tick(1); guard++; end
    total++; if (OUT_row !== 4'b0111) begin bad++; $display("FAIL midreset_row3: got %b want 0111", OUT_row); end
    keys[14] = 1'b1;
    tick(9);
    IN_reset = 1'b0;
    #1;
    total++; if (OUT_row !== 4'b1110) begin bad++; $display("FAIL midreset_row_async: got %b want 1110", OUT_row); end
    tick(2);
    total++; if (strobe_cnt != base) begin bad++; $display("FAIL midreset_aborted: got %0d strobes want 0", strobe_cnt - base); end
    IN_reset = 1'b1;
    wait_strobe(base, 60, seen);
    total++; if (!seen) begin bad++; $display("FAIL midreset_restrobe: got none want 1 within 60 cycles"); end
    total++; if (OUT_value !== 4'd14) begin bad++; $display("FAIL midreset_value: got %0d want 14", OUT_value); end
    tick(10);
    total++; if (strobe_cnt - base != 1) begin bad++; $display("FAIL midreset_count: got %0d want 1", strobe_cnt - base); end
    keys[14] = 1'b0;
    tick(30);
  endtask

  task automatic test_repeat;
    int base, press_cyc, n, t0, exp_t;
    base = strobe_cnt;
    keys[7] = 1'b1;
    press_cyc = cyc;
    tick(100);
    keys[7] = 1'b0;
    tick(30);
    n = strobe_cnt - base;
    total++; if (OUT_held !== 1'b0) begin bad++; $display("FAIL repeat_released: got %b want 0", OUT_held); end
`ifdef KEYPAD_SCAN_REPEAT_EN
    total++; if (n < 4) begin bad++; $display("FAIL repeat_count: got %0d want >= 4", n); end
    if (n > 0) begin
      t0 = strobe_cyc[base];
      for (int i = 0; i < n; i++) begin
        exp_t = (i == 0) ? t0 : t0 + REPEAT_DELAY + REPEAT_PERIOD * (i - 1);
        total++; if (strobe_cyc[base+i] != exp_t) begin bad++; $display("FAIL repeat_time_%0d: got %0d want %0d", i, strobe_cyc[base+i] - press_cyc, exp_t - press_cyc); end
        total++; if (strobe_val[base+i] != 7) begin bad++; $display("FAIL repeat_value_%0d: got %0d want 7", i, strobe_val[base+i]); end
      end
    end
`else
    total++; if (n != 1) begin bad++; $display("FAIL norepeat_count: got %0d want 1", n); end
    if (n > 0) begin
      total++; if (strobe_val[base] != 7) begin bad++; $display("FAIL norepeat_value: got %0d want 7", strobe_val[base]); end
    end
`endif
  endtask

  initial begin
    test_reset;
    test_idle_rotation;
    test_single_key;
    test_chatter;
    test_multi_col;
    test_reset_mid_press;
    test_repeat;
    total++; if (dbl_cnt != 0) begin bad++; $display("FAIL key_back_to_back: got %0d double pulses want 0", dbl_cnt); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
